// File: rtl/ahb_apb_bridge.sv
// AHB-Lite to APB bridge: one AHB single transfer at a time becomes an APB SETUP/ACCESS pair.
// Optional build macro APB_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES cycles with an AHB ERROR.
//
// state  | meaning
// IDLE   | waiting for an AHB transfer; HREADYOUT=1
// WDATA  | AHB write data phase, HWDATA captured into PWDATA at end of cycle
// SETUP  | APB setup phase, PSEL=1 PENABLE=0
// ACCESS | APB access phase, PSEL=1 PENABLE=1, waits for PREADY
// ERR1   | first AHB error cycle, HREADYOUT=0 HRESP=1
// ERR2   | second AHB error cycle, HREADYOUT=1 HRESP=1
module ahb_apb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HRESP,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state;
  logic   accept;
  logic   tmo_hit;
  logic   unused_inputs;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("ahb_apb_bridge: TIMEOUT_CYCLES must be in 2..255");
  end

  // Every access is a full word and SEQ is handled like NONSEQ.
  assign unused_inputs = ^{HSIZE, HTRANS[0]};

  assign accept = HSEL & HREADY & HTRANS[1];

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;
  // The cycle in which the count reaches TMO_LAST is the last allowed ACCESS cycle.
  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            PADDR     <= HADDR;
            PWRITE    <= HWRITE;
            HREADYOUT <= 1'b0;
            if (HWRITE) begin
              state <= ST_WDATA;
            end else begin
              state <= ST_SETUP;
              PSEL  <= 1'b1;
            end
          end
        end
        ST_WDATA: begin
          PWDATA <= HWDATA;
          PSEL   <= 1'b1;
          state  <= ST_SETUP;
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        ST_ACCESS: begin
          // PREADY is checked first so a late ready still beats the timeout.
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (PSLVERR) begin
              HRESP <= 1'b1;
              state <= ST_ERR1;
            end else begin
              HREADYOUT <= 1'b1;
              state     <= ST_IDLE;
              if (!PWRITE) HRDATA <= PRDATA;
            end
          end else if (tmo_hit) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            HRESP   <= 1'b1;
            state   <= ST_ERR1;
          end else begin
`ifdef APB_TIMEOUT_EN
            tmo_cnt <= tmo_cnt + 8'd1;
`endif
          end
        end
        ST_ERR1: begin
          HREADYOUT <= 1'b1;
          state     <= ST_ERR2;
        end
        ST_ERR2: begin
          HRESP <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge: reset, write, waited read, slave error, back-to-back,
// ACCESS hold (or timeout when APB_TIMEOUT_EN is defined) and reset in mid-ACCESS.
module tb_ahb_apb_bridge;

  logic        PCLK;
  logic        PRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_vec = 0;
  int n_err = 0;

  ahb_apb_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HREADYOUT(HREADYOUT),
    .HRDATA   (HRDATA),
    .HRESP    (HRESP),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(negedge PCLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] addr, input logic wr);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = addr;
    HWRITE = wr;
  endtask

  task automatic drive_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
  endtask

  initial begin
    PRESETn = 1'b0;
    HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010;
    HWDATA = '0; HREADY = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick(); tick();

    chk("rst_hreadyout", HREADYOUT, 1);
    chk("rst_hresp",     HRESP,     0);
    chk("rst_hrdata",    HRDATA,    0);
    chk("rst_psel",      PSEL,      0);
    chk("rst_penable",   PENABLE,   0);
    chk("rst_paddr",     PADDR,     0);
    chk("rst_pwrite",    PWRITE,    0);
    chk("rst_pwdata",    PWDATA,    0);
    PRESETn = 1'b1;
    tick();

    // Transfers that must not be accepted
    req(32'h100, 1'b0); HREADY = 1'b0;
    tick();
    chk("noacc_hready_psel", PSEL, 0);
    chk("noacc_hready_hro",  HREADYOUT, 1);
    HREADY = 1'b1; HTRANS = 2'b01;
    tick();
    chk("noacc_busy_psel", PSEL, 0);
    HSEL = 1'b0; HTRANS = 2'b10;
    tick();
    chk("noacc_hsel_psel",  PSEL, 0);
    chk("noacc_hsel_hresp", HRESP, 0);
    drive_idle();

    // Write 0x10 <- 0xDEADBEEF, no wait states
    req(32'h10, 1'b1);
    tick();
    drive_idle(); HWDATA = 32'hDEADBEEF; PREADY = 1'b1;
    chk("wr_wdata_psel",   PSEL, 0);
    chk("wr_wdata_hro",    HREADYOUT, 0);
    chk("wr_wdata_paddr",  PADDR, 32'h10);
    chk("wr_wdata_pwrite", PWRITE, 1);
    tick();
    HWDATA = '0;
    chk("wr_setup_psel",    PSEL, 1);
    chk("wr_setup_penable", PENABLE, 0);
    chk("wr_setup_pwdata",  PWDATA, 32'hDEADBEEF);
    tick();
    chk("wr_access_psel",    PSEL, 1);
    chk("wr_access_penable", PENABLE, 1);
    chk("wr_access_hro",     HREADYOUT, 0);
    chk("wr_access_pwdata",  PWDATA, 32'hDEADBEEF);
    tick();
    chk("wr_done_hro",     HREADYOUT, 1);
    chk("wr_done_hresp",   HRESP, 0);
    chk("wr_done_psel",    PSEL, 0);
    chk("wr_done_penable", PENABLE, 0);
    chk("wr_done_hrdata",  HRDATA, 0);

    // Read 0x24 with three wait states
    PREADY = 1'b0; PRDATA = 32'hBAD0BAD0;
    req(32'h24, 1'b0);
    tick();
    drive_idle();
    chk("rd_setup_psel",    PSEL, 1);
    chk("rd_setup_penable", PENABLE, 0);
    chk("rd_setup_paddr",   PADDR, 32'h24);
    chk("rd_setup_pwrite",  PWRITE, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("rd_wait_penable", PENABLE, 1);
      chk("rd_wait_hro",     HREADYOUT, 0);
      chk("rd_wait_paddr",   PADDR, 32'h24);
      if (i == 3) begin
        PREADY = 1'b1; PRDATA = 32'h1234;
      end
      tick();
    end
    chk("rd_done_hro",    HREADYOUT, 1);
    chk("rd_done_hrdata", HRDATA, 32'h1234);
    chk("rd_done_hresp",  HRESP, 0);
    chk("rd_done_psel",   PSEL, 0);

    // Read with slave error; a transfer offered in ERR2 is ignored
    PRDATA = 32'hFFFF0000; PSLVERR = 1'b1;
    req(32'h30, 1'b0);
    tick();
    drive_idle();
    tick();
    chk("err_access_penable", PENABLE, 1);
    tick();
    chk("err1_hro",     HREADYOUT, 0);
    chk("err1_hresp",   HRESP, 1);
    chk("err1_psel",    PSEL, 0);
    chk("err1_penable", PENABLE, 0);
    tick();
    chk("err2_hro",   HREADYOUT, 1);
    chk("err2_hresp", HRESP, 1);
    req(32'h50, 1'b0);
    tick();
    drive_idle(); PSLVERR = 1'b0;
    chk("err_idle_hro",    HREADYOUT, 1);
    chk("err_idle_hresp",  HRESP, 0);
    chk("err_idle_psel",   PSEL, 0);
    chk("err_idle_hrdata", HRDATA, 32'h1234);

    // Back-to-back: write 0x0, then read 0x4 offered in the completion cycle
    PREADY = 1'b1; PRDATA = 32'hCAFE0004;
    req(32'h0, 1'b1);
    tick();
    drive_idle(); HWDATA = 32'h0BADF00D;
    tick();
    tick();
    tick();
    chk("b2b_wr_done_hro", HREADYOUT, 1);
    req(32'h4, 1'b0);
    tick();
    drive_idle();
    chk("b2b_rd_setup_psel",    PSEL, 1);
    chk("b2b_rd_setup_penable", PENABLE, 0);
    chk("b2b_rd_setup_paddr",   PADDR, 32'h4);
    chk("b2b_rd_setup_pwrite",  PWRITE, 0);
    chk("b2b_pwdata_held",      PWDATA, 32'h0BADF00D);
    tick();
    tick();
    chk("b2b_rd_hro",    HREADYOUT, 1);
    chk("b2b_rd_hrdata", HRDATA, 32'hCAFE0004);

    // PREADY held low: timeout abort if enabled, otherwise indefinite hold
    PREADY = 1'b0;
    req(32'h60, 1'b0);
    tick();
    drive_idle();
    tick();
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("to_access_psel", PSEL, 1);
      tick();
    end
    chk("to_err1_psel",    PSEL, 0);
    chk("to_err1_penable", PENABLE, 0);
    chk("to_err1_hro",     HREADYOUT, 0);
    chk("to_err1_hresp",   HRESP, 1);
    tick();
    chk("to_err2_hro",   HREADYOUT, 1);
    chk("to_err2_hresp", HRESP, 1);
    tick();
    chk("to_idle_hresp",  HRESP, 0);
    chk("to_idle_hrdata", HRDATA, 32'hCAFE0004);
`else
    for (int i = 0; i < 20; i++) begin
      chk("hold_penable", PENABLE, 1);
      chk("hold_hro",     HREADYOUT, 0);
      tick();
    end
    PRDATA = 32'h600D; PREADY = 1'b1;
    tick();
    chk("hold_done_hro",    HREADYOUT, 1);
    chk("hold_done_hrdata", HRDATA, 32'h600D);
    PREADY = 1'b0;
`endif

    // Reset asserted in the middle of an ACCESS cycle
    req(32'h44, 1'b0);
    tick();
    drive_idle();
    tick();
    tick();
    chk("mid_access_psel", PSEL, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("midrst_psel",    PSEL, 0);
    chk("midrst_penable", PENABLE, 0);
    chk("midrst_hro",     HREADYOUT, 1);
    chk("midrst_hresp",   HRESP, 0);
    chk("midrst_paddr",   PADDR, 0);
    chk("midrst_hrdata",  HRDATA, 0);
    tick();
    PRESETn = 1'b1;
    tick();
    tick();
    chk("postrst_psel", PSEL, 0);
    chk("postrst_hro",  HREADYOUT, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
